aes_sbox_lanes: RTL and testbench
=================================

Name: aes_sbox_lanes

Overview:
- Parametrised multi-lane AES byte-substitution engine for SubBytes and InvSubBytes.
- Applies the forward or inverse S-box to LANES bytes per word.
- Uses a valid/ready elastic pipeline of PIPE register stages; direction is carried per word.
- Sits between the state register and the ShiftRows/MixColumns datapath of the next-generation AES core, and also serves the key-expansion SubWord path (LANES=4).

Parameters:
- LANES, 4: number of byte lanes per word; 1..16.
- PIPE, 1: register stages between input and output; 1 or 2.
- INV_EN, 1: 1 instantiates the inverse S-box per lane; 0 gives a forward-only build.

Ports:
- clk  input  1  block clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the word
- in_data  input  8*LANES  byte lane k = in_data[8k+7:8k]
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the word
- out_inv  output  1  direction bit carried with the word
- out_data  output  8*LANES  substituted bytes, lane-aligned with in_data
- busy  output  1  any pipeline stage holds a valid word
- inv_err  output  1  one-cycle pulse when in_inv=1 is accepted while INV_EN=0
- word_cnt  output  16  count of words delivered at the output

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits, out_valid, busy, inv_err and word_cnt clear to 0; out_data and out_inv clear to 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight word; no partial output is produced.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready.
- Lane function: each lane independently computes d = S(a) for forward or S^-1(a) for inverse, using the standard FIPS-197 tables. All lanes of a word use the same in_inv.
- Substitution placement:
  - Substitution is combinational from the input and is registered into stage 0.
  - With PIPE=2, stage 1 is a pure register copy; no logic split is required.
- Stage rules:
  - Stage i has valid_i, data_i and inv_i.
  - Stage i loads when !valid_i or the stage downstream of it advances.
  - The last stage advances on an output transfer.
  - in_ready = !valid_0 | advance_0. This is combinational from out_ready, with no combinational path from in_valid to in_ready.
- Throughput and latency:
  - With out_ready held at 1, throughput is one word per cycle.
  - Latency is exactly PIPE cycles: a word accepted at edge t has out_valid=1 after edge t+PIPE-1 and is presented in cycle t+PIPE.
- Backpressure:
  - With out_ready=0, out_data and out_inv hold stable and out_valid stays 1 until transfer.
  - Words are never dropped, duplicated or reordered.
  - When every stage is valid and out_ready=0, in_ready=0.
- Simultaneous in/out transfer when full: the pipeline shifts and accepts, holding full occupancy with no bubble.
- busy = OR of all stage valid bits.
- INV_EN=0:
  - The inverse table is not instantiated and every word is substituted forward.
  - out_inv still reflects the captured in_inv.
  - inv_err pulses for one cycle on the edge following such an accept.
- word_cnt: increments by 1 on each output transfer and wraps from 0xFFFF to 0x0000.
- Constraint: direction switching between consecutive words costs no bubbles.

Test Plan:
- LANES=4, PIPE=1, forward; in_data=0x53_01_00_FF, in_inv=0, out_ready=1 → one cycle later out_data=0xED_7C_63_16, out_inv=0, word_cnt=1.
- Inverse, same config; in_data=0xED_7C_63_16, in_inv=1 → out_data=0x53_01_00_FF; also in_data byte 0x00 → 0x52.
- PIPE=2 streaming; 8 back-to-back words with alternating in_inv → outputs appear in order 2 cycles after each accept, no bubbles, word_cnt=8.
- Backpressure, PIPE=2:
  - Hold out_ready=0 while feeding 3 words → in_ready drops after 2 accepts and out_data stays stable.
  - Release out_ready → all 3 words delivered in order.
  - During the stall, simultaneous in/out transfer keeps full occupancy.
- Reset mid-stream: assert rst for 1 cycle with 2 words in flight → out_valid=0, busy=0, word_cnt=0 next cycle; in_ready=1; no stale word emerges.
- INV_EN=0 and wrap:
  - in_inv=1 with byte 0x00 → out_data byte 0x63 and a single-cycle inv_err pulse.
  - Preload via 65536 transfers → word_cnt wraps to 0x0000.

Source files
------------

// File: rtl/aes_sbox_lanes_if.sv
// Word-level valid/ready bus for the AES byte-substitution lanes.
// The master drives input words and output backpressure. The slave is the S-box engine.
interface aes_sbox_lanes_if #(
    parameter int unsigned LANES = 4
);
    localparam int unsigned DW = 8 * LANES;

    logic          in_valid;
    logic          in_ready;
    logic          in_inv;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_inv;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid,
        output in_inv,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inv,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inv,
        output out_data
    );
endinterface

// File: rtl/aes_sbox_lanes.sv
// Multi-lane AES SubBytes / InvSubBytes engine with a 1- or 2-stage elastic pipeline.
// Each lane is built arithmetically as a GF(2^8) inverse combined with the FIPS-197 affine map.
// The substitution is combinational from the input and lands in stage 0.
// Stage 1, when present, is a plain register copy.
module aes_sbox_lanes #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned PIPE   = 1,
    parameter int unsigned INV_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_sbox_lanes_if.slave        bus,
    output logic                   busy,
    output logic                   inv_err,
    output logic [15:0]            word_cnt
);
    localparam int unsigned DW = 8 * LANES;

    typedef struct packed {
        logic          inv;
        logic [DW-1:0] data;
    } word_t;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254. The chain is a^3, a^7 and so on up to a^127, then one squaring.
    // The input 0 maps to 0, as the S-box definition requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), a);
        end
        return gf_mul(r, r);
    endfunction

    // Forward S-box: inverse, then the affine map b ^ rotl1..4(b) ^ 0x63.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then the inverse.
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    logic [DW-1:0] w_sub;
    logic          w_ld0;
    logic          w_ld_last;
    logic          w_acc;
    logic          w_out_valid;
    logic          w_out_xfer;

    logic          r_v0;
    word_t         r_s0;
    logic          r_inv_err;
    logic [15:0]   r_word_cnt;

    // Per-lane substitution. A forward-only build never instantiates the inverse table.
    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        logic [7:0] w_a;
        logic [7:0] w_fwd;
        assign w_a   = bus.in_data[8*k +: 8];
        assign w_fwd = sbox_fwd(w_a);
        if (INV_EN != 0) begin : g_inv
            logic [7:0] w_inv;
            assign w_inv             = sbox_inv(w_a);
            assign w_sub[8*k +: 8]   = bus.in_inv ? w_inv : w_fwd;
        end else begin : g_fwd_only
            assign w_sub[8*k +: 8]   = w_fwd;
        end
    end

    // Stage control and output mapping for the chosen depth.
    if (PIPE == 2) begin : g_pipe2
        logic  r_v1;
        word_t r_s1;

        assign w_ld_last    = ~r_v1 | bus.out_ready;
        assign w_ld0        = ~r_v0 | w_ld_last;
        assign w_out_valid  = r_v1;
        assign bus.out_inv  = r_s1.inv;
        assign bus.out_data = r_s1.data;
        assign busy         = r_v0 | r_v1;

        // Stage 1 copies stage 0 whenever it is empty or its word leaves.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v1 <= 1'b0;
                r_s1 <= '0;
            end else if (w_ld_last) begin
                r_v1 <= r_v0;
                if (r_v0) r_s1 <= r_s0;
            end
        end
    end else begin : g_pipe1
        assign w_ld_last    = ~r_v0 | bus.out_ready;
        assign w_ld0        = w_ld_last;
        assign w_out_valid  = r_v0;
        assign bus.out_inv  = r_s0.inv;
        assign bus.out_data = r_s0.data;
        assign busy         = r_v0;
    end

    assign bus.in_ready  = w_ld0;
    assign bus.out_valid = w_out_valid;
    assign w_acc         = bus.in_valid & w_ld0;
    assign w_out_xfer    = w_out_valid & bus.out_ready;
    assign inv_err       = r_inv_err;
    assign word_cnt      = r_word_cnt;

    // Stage 0 captures the substituted word together with its direction bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_s0 <= '0;
        end else if (w_ld0) begin
            r_v0 <= bus.in_valid;
            if (bus.in_valid) r_s0 <= word_t'{inv: bus.in_inv, data: w_sub};
        end
    end

    // Flag inverse requests that a forward-only build cannot honour, and count delivered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_err  <= 1'b0;
            r_word_cnt <= 16'h0000;
        end else begin
            r_inv_err <= (INV_EN == 0) & w_acc & bus.in_inv;
            if (w_out_xfer) r_word_cnt <= r_word_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_aes_sbox_lanes.sv
// Directed bench for aes_sbox_lanes.
// There are three builds: PIPE=1 with inverse, PIPE=2 with inverse, and PIPE=1 forward-only.
// Expected words go into one queue per build at accept time and are checked when delivered.
module tb_aes_sbox_lanes;

    typedef struct packed {
        logic        inv;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  fwd_t [256];
    logic [7:0]  inv_t [256];

    exp_t        q_a [$];
    exp_t        q_b [$];
    exp_t        q_c [$];

    logic        busy_a, busy_b, busy_c;
    logic        inv_err_a, inv_err_b, inv_err_c;
    logic [15:0] word_cnt_a, word_cnt_b, word_cnt_c;

    aes_sbox_lanes_if #(.LANES(4)) if_a ();
    aes_sbox_lanes_if #(.LANES(4)) if_b ();
    aes_sbox_lanes_if #(.LANES(4)) if_c ();

    aes_sbox_lanes #(.LANES(4), .PIPE(1), .INV_EN(1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .busy(busy_a), .inv_err(inv_err_a), .word_cnt(word_cnt_a)
    );
    aes_sbox_lanes #(.LANES(4), .PIPE(2), .INV_EN(1)) u_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .busy(busy_b), .inv_err(inv_err_b), .word_cnt(word_cnt_b)
    );
    aes_sbox_lanes #(.LANES(4), .PIPE(1), .INV_EN(0)) u_c (
        .clk(clk), .rst(rst), .bus(if_c),
        .busy(busy_c), .inv_err(inv_err_c), .word_cnt(word_cnt_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] d, input logic inv, input logic inv_en);
        exp_t e;
        e.inv = inv;
        for (int k = 0; k < 4; k++) begin
            e.data[8*k +: 8] = (inv && inv_en) ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic send_a(input logic [31:0] d, input logic inv);
        if_a.in_valid = 1'b1;
        if_a.in_data  = d;
        if_a.in_inv   = inv;
        step();
        if_a.in_valid = 1'b0;
    endtask

    // Scoreboard for each build: compare delivered words, then record newly accepted ones.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
        end else begin
            if (if_a.out_valid && if_a.out_ready) begin
                if (q_a.size() == 0) check("a_unexpected_word", 64'(if_a.out_data), 64'hDEAD);
                else check("a_out", 64'({if_a.out_inv, if_a.out_data}), 64'(q_a.pop_front()));
            end
            if (if_a.in_valid && if_a.in_ready) q_a.push_back(mk_exp(if_a.in_data, if_a.in_inv, 1'b1));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_b.delete();
        end else begin
            if (if_b.out_valid && if_b.out_ready) begin
                if (q_b.size() == 0) check("b_unexpected_word", 64'(if_b.out_data), 64'hDEAD);
                else check("b_out", 64'({if_b.out_inv, if_b.out_data}), 64'(q_b.pop_front()));
            end
            if (if_b.in_valid && if_b.in_ready) q_b.push_back(mk_exp(if_b.in_data, if_b.in_inv, 1'b1));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_c.delete();
        end else begin
            if (if_c.out_valid && if_c.out_ready) begin
                if (q_c.size() == 0) check("c_unexpected_word", 64'(if_c.out_data), 64'hDEAD);
                else check("c_out", 64'({if_c.out_inv, if_c.out_data}), 64'(q_c.pop_front()));
            end
            if (if_c.in_valid && if_c.in_ready) q_c.push_back(mk_exp(if_c.in_data, if_c.in_inv, 1'b0));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  p, q, x;
        logic [9:0]  ov;
        int          rdy_lo;
        int          stale;
        logic [31:0] w0, w1, w2;
        logic [32:0] hold;

        // Reference tables: walk the generator 3 and its inverse together.
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        if_a.in_valid = 1'b0; if_a.in_inv = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_inv = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b1;
        if_c.in_valid = 1'b0; if_c.in_inv = 1'b0; if_c.in_data = '0; if_c.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        samp();
        check("rst_a_out_valid", 64'(if_a.out_valid), 64'd0);
        check("rst_a_in_ready",  64'(if_a.in_ready),  64'd1);
        check("rst_a_busy",      64'(busy_a),         64'd0);
        check("rst_a_word_cnt",  64'(word_cnt_a),     64'd0);
        check("rst_a_out_word",  64'({if_a.out_inv, if_a.out_data}), 64'd0);
        check("rst_a_inv_err",   64'(inv_err_a),      64'd0);
        check("rst_b_out_valid", 64'(if_b.out_valid), 64'd0);
        check("rst_b_in_ready",  64'(if_b.in_ready),  64'd1);
        check("rst_b_busy",      64'(busy_b),         64'd0);
        check("rst_c_inv_err",   64'(inv_err_c),      64'd0);

        // PIPE=1 forward vector
        step();
        send_a(32'h530100FF, 1'b0);
        samp();
        check("fwd_valid", 64'(if_a.out_valid), 64'd1);
        check("fwd_data",  64'(if_a.out_data),  64'hED7C6316);
        check("fwd_inv",   64'(if_a.out_inv),   64'd0);
        step();
        samp();
        check("fwd_cnt",       64'(word_cnt_a),     64'd1);
        check("fwd_idle_after", 64'(if_a.out_valid), 64'd0);

        // PIPE=1 inverse vectors
        step();
        send_a(32'hED7C6316, 1'b1);
        samp();
        check("inv_data",    64'(if_a.out_data), 64'h530100FF);
        check("inv_inv",     64'(if_a.out_inv),  64'd1);
        check("inv_no_err",  64'(inv_err_a),     64'd0);
        step();
        send_a(32'h00000000, 1'b1);
        samp();
        check("inv_zero", 64'(if_a.out_data), 64'h52525252);
        step();
        samp();
        check("inv_cnt", 64'(word_cnt_a), 64'd3);

        // PIPE=2 streaming: 8 words with alternating direction
        step();
        ov = '0;
        rdy_lo = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                if_b.in_valid = 1'b1;
                if_b.in_data  = $urandom;
                if_b.in_inv   = c[0];
            end else begin
                if_b.in_valid = 1'b0;
            end
            samp();
            ov = {if_b.out_valid, ov[9:1]};
            if (c < 8 && !if_b.in_ready) rdy_lo++;
            step();
        end
        check("stream_valid_pattern", 64'(ov), 64'(10'b1111111100));
        check("stream_ready_drops",   64'(rdy_lo), 64'd0);
        samp();
        check("stream_cnt",  64'(word_cnt_b), 64'd8);
        check("stream_idle", 64'(busy_b),     64'd0);

        // PIPE=2 backpressure
        step();
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        if_b.out_ready = 1'b0;
        if_b.in_valid  = 1'b1;
        if_b.in_data   = w0;
        if_b.in_inv    = 1'b0;
        samp();
        check("bp_ready_0", 64'(if_b.in_ready), 64'd1);
        step();
        if_b.in_data = w1;
        if_b.in_inv  = 1'b1;
        samp();
        check("bp_ready_1", 64'(if_b.in_ready), 64'd1);
        step();
        if_b.in_data = w2;
        if_b.in_inv  = 1'b0;
        samp();
        check("bp_ready_full", 64'(if_b.in_ready),  64'd0);
        check("bp_valid",      64'(if_b.out_valid), 64'd1);
        hold = {if_b.out_inv, if_b.out_data};
        check("bp_head_word", 64'(hold), 64'(mk_exp(w0, 1'b0, 1'b1)));
        for (int k = 0; k < 3; k++) begin
            step();
            samp();
            check("bp_hold",       64'({if_b.out_inv, if_b.out_data}), 64'(hold));
            check("bp_hold_ready", 64'(if_b.in_ready), 64'd0);
        end
        step();
        if_b.out_ready = 1'b1;
        samp();
        check("bp_swap_ready", 64'(if_b.in_ready), 64'd1);
        step();
        if_b.in_valid  = 1'b0;
        if_b.out_ready = 1'b0;
        samp();
        check("bp_swap_valid", 64'(if_b.out_valid), 64'd1);
        check("bp_swap_word",  64'({if_b.out_inv, if_b.out_data}), 64'(mk_exp(w1, 1'b1, 1'b1)));
        check("bp_swap_full",  64'(if_b.in_ready), 64'd0);
        check("bp_swap_busy",  64'(busy_b), 64'd1);
        step();
        if_b.out_ready = 1'b1;
        for (int k = 0; k < 10 && q_b.size() != 0; k++) step();
        check("bp_drain", 64'(q_b.size()), 64'd0);
        samp();
        check("bp_cnt", 64'(word_cnt_b), 64'd11);

        // Reset with two words in flight on PIPE=2
        step();
        if_b.in_valid = 1'b1;
        if_b.in_data  = $urandom;
        if_b.in_inv   = 1'b0;
        step();
        if_b.in_data  = $urandom;
        if_b.in_inv   = 1'b1;
        step();
        if_b.in_valid = 1'b0;
        rst = 1'b1;
        samp();
        check("mid_busy_before", 64'(busy_b), 64'd1);
        step();
        rst = 1'b0;
        samp();
        check("mid_out_valid", 64'(if_b.out_valid), 64'd0);
        check("mid_busy",      64'(busy_b),         64'd0);
        check("mid_cnt",       64'(word_cnt_b),     64'd0);
        check("mid_in_ready",  64'(if_b.in_ready),  64'd1);
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            samp();
            if (if_b.out_valid) stale++;
        end
        check("mid_no_stale", 64'(stale), 64'd0);

        // Forward-only build: an inverse request is substituted forward and flagged
        step();
        if_c.in_valid = 1'b1;
        if_c.in_data  = 32'h00000000;
        if_c.in_inv   = 1'b1;
        step();
        if_c.in_valid = 1'b0;
        samp();
        check("fo_inv_err",  64'(inv_err_c),     64'd1);
        check("fo_data",     64'(if_c.out_data), 64'h63636363);
        check("fo_inv_bit",  64'(if_c.out_inv),  64'd1);
        step();
        samp();
        check("fo_err_pulse", 64'(inv_err_c),  64'd0);
        check("fo_cnt",       64'(word_cnt_c), 64'd1);
        step();
        if_c.in_valid = 1'b1;
        if_c.in_data  = 32'h530100FF;
        if_c.in_inv   = 1'b0;
        step();
        if_c.in_valid = 1'b0;
        samp();
        check("fo_fwd_no_err", 64'(inv_err_c),     64'd0);
        check("fo_fwd_data",   64'(if_c.out_data), 64'hED7C6316);

        // word_cnt wrap: 2 words delivered so far, 65533 more reach 0xFFFF
        step();
        for (int k = 0; k < 65533; k++) begin
            if_c.in_valid = 1'b1;
            if_c.in_data  = $urandom;
            if_c.in_inv   = 1'($urandom_range(0, 1));
            step();
        end
        if_c.in_valid = 1'b0;
        step();
        samp();
        check("wrap_ffff", 64'(word_cnt_c), 64'hFFFF);
        step();
        if_c.in_valid = 1'b1;
        if_c.in_data  = 32'h01020304;
        if_c.in_inv   = 1'b0;
        step();
        if_c.in_valid = 1'b0;
        step();
        samp();
        check("wrap_zero", 64'(word_cnt_c), 64'h0000);
        check("wrap_queue_empty", 64'(q_c.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
